// File: rtl/viterbi_sym_unpacker.sv
// Byte-to-symbol unpacker that feeds viterbi_core.
// Each input byte carries four 2-bit rate-1/2 hard-decision symbols. The block
// frames the stream with init_frame / frame_done pulses and never consumes a
// byte beyond the end of the current frame.
module viterbi_sym_unpacker #(
   parameter int CNT_W     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic [CNT_W-1:0] frame_len,
   input  logic [7:0]       in_byte,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       rx_sym,
   output logic             rx_sym_valid,
   input  logic             rx_sym_ready,
   output logic             init_frame,
   output logic             frame_done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

   state_t           state;
   logic [7:0]       sym_buf;
   logic [2:0]       nsym;
   logic [CNT_W-1:0] rem;
   logic             sym_acc;
   logic             byte_acc;
   logic [7:0]       shifted_buf;

   // The current symbol always sits at the outgoing end of the shift buffer.
   assign rx_sym       = MSB_FIRST ? sym_buf[7:6] : sym_buf[1:0];
   assign rx_sym_valid = (state == RUN) && (nsym != 3'd0);

   // Lookahead ready: a new byte may land in the same cycle the last buffered
   // symbol leaves, unless that symbol ends the frame.
   assign in_ready = (state == RUN) &&
                     ((nsym == 3'd0) ||
                      ((nsym == 3'd1) && rx_sym_ready && (rem > CNT_W'(1))));

   assign sym_acc  = rx_sym_valid && rx_sym_ready;
   assign byte_acc = in_valid && in_ready;

   // Shift direction follows symbol order so the next symbol moves into rx_sym.
   assign shifted_buf = MSB_FIRST ? {sym_buf[5:0], 2'b00} : {2'b00, sym_buf[7:2]};

   // Frame FSM with registered init_frame, frame_done and busy pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sym_buf    <= 8'd0;
         nsym       <= 3'd0;
         rem        <= '0;
         init_frame <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         init_frame <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  nsym    <= 3'd0;
                  sym_buf <= 8'd0;
                  busy    <= 1'b1;
                  if (frame_len == '0) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                  end else begin
                     rem        <= frame_len;
                     state      <= INIT;
                     init_frame <= 1'b1;
                  end
               end
            end
            INIT: begin
               state <= RUN;
            end
            RUN: begin
               if (sym_acc) begin
                  rem <= rem - CNT_W'(1);
                  if (rem == CNT_W'(1)) begin
                     state      <= DONE;
                     frame_done <= 1'b1;
                     nsym       <= 3'd0;
                     sym_buf    <= 8'd0;
                  end else begin
                     sym_buf <= shifted_buf;
                     nsym    <= nsym - 3'd1;
                  end
               end
               if (byte_acc) begin
                  sym_buf <= in_byte;
                  nsym    <= 3'd4;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_sym_unpacker.sv
// Self-checking bench for viterbi_sym_unpacker: a counting model of the frame
// (symbols delivered, bytes consumed, symbols still buffered) is compared with
// the DUT on every falling edge, plus literal checks for known vectors.
module tb_viterbi_sym_unpacker;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic [15:0] frame_len;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  rx_sym;
   logic        rx_sym_valid;
   logic        rx_sym_ready;
   logic        init_frame;
   logic        frame_done;
   logic        busy;

   viterbi_sym_unpacker #(.CNT_W(16), .MSB_FIRST(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_start  (frame_start),
      .frame_len    (frame_len),
      .in_byte      (in_byte),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rx_sym       (rx_sym),
      .rx_sym_valid (rx_sym_valid),
      .rx_sym_ready (rx_sym_ready),
      .init_frame   (init_frame),
      .frame_done   (frame_done),
      .busy         (busy)
   );

   int check_count = 0;
   int pass_count  = 0;

   logic [7:0] frame_bytes[$];
   logic [1:0] exp_q[$];
   logic [1:0] sym_log[$];

   int   m_busy = 0, m_init_due = 0, m_done_due = 0;
   int   m_len = 0, m_deliv = 0, m_bytes = 0;
   int   frames_done = 0, init_count = 0, done_count = 0;
   int   cyc = 0, first_acc_cyc = -1, last_acc_cyc = -1;
   logic prev_valid = 1'b0, prev_ready = 1'b0, prev_byte_acc = 1'b0;
   logic [1:0] prev_sym = 2'd0;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends even if the DUT wedges.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Scores one comparison and reports it on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Per-cycle compare against the counting model of the current frame.
   always @(negedge clk) begin : compare
      int   pending;
      int   next_init, next_done, next_busy;
      logic running, exp_ready, exp_valid, byte_acc, sym_acc;
      logic [1:0] e;
      cyc++;
      if (rst) begin
         m_busy = 0; m_init_due = 0; m_done_due = 0;
         m_deliv = 0; m_bytes = 0; m_len = 0;
         prev_valid = 1'b0; prev_ready = 1'b0; prev_byte_acc = 1'b0;
      end else begin
         running   = (m_busy != 0) && (m_init_due == 0) && (m_done_due == 0);
         pending   = m_bytes * 4 - m_deliv;
         exp_ready = running && ((pending == 0) ||
                     ((pending == 1) && rx_sym_ready && ((m_len - m_deliv) > 1)));
         exp_valid = running && (pending != 0);
         checkOutput("busy", busy, m_busy);
         checkOutput("init_frame", init_frame, m_init_due);
         checkOutput("frame_done", frame_done, m_done_due);
         checkOutput("in_ready", in_ready, exp_ready);
         checkOutput("rx_sym_valid", rx_sym_valid, exp_valid);
         if (prev_valid && !prev_ready) checkOutput("rx_sym_hold", rx_sym, prev_sym);
         if (rx_sym_valid && !prev_valid) checkOutput("valid_after_byte", prev_byte_acc, 1);

         byte_acc = in_valid && in_ready;
         sym_acc  = rx_sym_valid && rx_sym_ready;
         if (init_frame) init_count++;
         if (frame_done) begin done_count++; frames_done++; end

         next_init = 0; next_done = 0; next_busy = m_busy;
         if (m_done_due != 0) next_busy = 0;
         if ((m_busy == 0) && frame_start) begin
            next_busy = 1;
            m_len   = int'(frame_len);
            m_deliv = 0;
            m_bytes = 0;
            if (frame_len == 16'd0) next_done = 1; else next_init = 1;
         end
         if (byte_acc) m_bytes++;
         if (sym_acc) begin
            if (exp_q.size() == 0) begin
               checkOutput("sym_overrun", 1, 0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("rx_sym", rx_sym, e);
            end
            sym_log.push_back(rx_sym);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            m_deliv++;
            if (m_deliv == m_len) next_done = 1;
         end

         prev_valid    = rx_sym_valid;
         prev_ready    = rx_sym_ready;
         prev_sym      = rx_sym;
         prev_byte_acc = byte_acc;
         m_init_due    = next_init;
         m_done_due    = next_done;
         m_busy        = next_busy;
      end
   end

   // Runs one frame: vmode 0 = always valid, 1 = random valid;
   // rmode 0 = always ready, 1 = random, 2 = fixed 1,0,0,1,0,1 pattern.
   // stray_at pulses frame_start after that many symbols; abort_at returns early.
   task automatic applyStimulus(input int len, input int vmode, input int rmode,
                                input int stray_at, input int abort_at);
      int idx = 0;
      int k = 0;
      int budget = 0;
      int start_done;
      int pat[6] = '{1, 0, 0, 1, 0, 1};
      logic [7:0] b;
      while (frame_bytes.size() < (len + 3) / 4) frame_bytes.push_back(8'($urandom));
      exp_q.delete();
      sym_log.delete();
      for (int i = 0; i < len; i++) begin
         b = frame_bytes[i / 4];
         exp_q.push_back(2'((b >> (6 - 2 * (i % 4))) & 8'h3));
      end
      start_done    = frames_done;
      init_count    = 0;
      done_count    = 0;
      first_acc_cyc = -1;
      last_acc_cyc  = -1;
      @(posedge clk); #1;
      frame_start  = 1'b1;
      frame_len    = 16'(len);
      in_valid     = 1'b0;
      rx_sym_ready = 1'b0;
      @(posedge clk); #1;
      frame_start = 1'b0;
      while ((frames_done == start_done) && (budget < 5000)) begin
         if ((abort_at >= 0) && (sym_log.size() >= abort_at)) return;
         in_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         in_byte  = (idx < frame_bytes.size()) ? frame_bytes[idx] : 8'($urandom);
         case (rmode)
            0:       rx_sym_ready = 1'b1;
            1:       rx_sym_ready = 1'($urandom_range(0, 1));
            default: rx_sym_ready = 1'(pat[k % 6]);
         endcase
         if ((stray_at >= 0) && (sym_log.size() >= stray_at)) begin
            frame_start = 1'b1;
            frame_len   = 16'd5;
            stray_at    = -1;
         end else begin
            frame_start = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         k++;
         budget++;
         @(posedge clk); #1;
      end
      checkOutput("frame_timeout", (budget < 5000), 1);
      frame_start = 1'b0;
      in_valid    = 1'b0;
   endtask

   // Checks the literal symbol sequence recorded for the last frame.
   task automatic checkLog(input string name, input logic [1:0] exp[$]);
      checkOutput({name, "_count"}, sym_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < sym_log.size(); i++)
         checkOutput(name, sym_log[i], exp[i]);
   endtask

   initial begin
      logic [1:0] exp1[$];
      logic [1:0] exp2[$];
      rst = 1'b1; frame_start = 1'b0; frame_len = 16'd0;
      in_byte = 8'd0; in_valid = 1'b0; rx_sym_ready = 1'b0;
      #1;
      checkOutput("reset_in_ready", in_ready, 0);
      checkOutput("reset_rx_sym", rx_sym, 0);
      checkOutput("reset_rx_sym_valid", rx_sym_valid, 0);
      checkOutput("reset_init_frame", init_frame, 0);
      checkOutput("reset_frame_done", frame_done, 0);
      checkOutput("reset_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      $display("[TB] vector 1: single byte 0xB4, length 4");
      frame_bytes = '{8'hB4};
      applyStimulus(4, 0, 0, -1, -1);
      exp1 = '{2'd2, 2'd3, 2'd1, 2'd0};
      checkLog("v1_sym", exp1);
      checkOutput("v1_consecutive", last_acc_cyc - first_acc_cyc, 3);
      checkOutput("v1_bytes", m_bytes, 1);
      checkOutput("v1_init_count", init_count, 1);

      $display("[TB] vector 2: bytes 0x1B 0xE4, length 6");
      frame_bytes = '{8'h1B, 8'hE4};
      applyStimulus(6, 0, 0, -1, -1);
      exp2 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
      checkLog("v2_sym", exp2);
      checkOutput("v2_bytes", m_bytes, 2);

      $display("[TB] vector 3: stalled consumer, length 8");
      frame_bytes.delete();
      applyStimulus(8, 0, 2, -1, -1);
      checkOutput("v3_count", sym_log.size(), 8);

      $display("[TB] vector 4: long frame, length 258");
      frame_bytes.delete();
      applyStimulus(258, 0, 0, -1, -1);
      checkOutput("v4_count", sym_log.size(), 258);
      checkOutput("v4_consecutive", last_acc_cyc - first_acc_cyc, 257);
      checkOutput("v4_bytes", m_bytes, 65);

      $display("[TB] vector 5: empty frame and stray frame_start");
      frame_bytes.delete();
      applyStimulus(0, 0, 0, -1, -1);
      checkOutput("v5_init_count", init_count, 0);
      checkOutput("v5_done_count", done_count, 1);
      checkOutput("v5_bytes", m_bytes, 0);
      frame_bytes.delete();
      applyStimulus(12, 0, 0, 3, -1);
      checkOutput("v5_stray_count", sym_log.size(), 12);
      checkOutput("v5_stray_done", done_count, 1);

      $display("[TB] vector 6: reset in the middle of a frame");
      frame_bytes.delete();
      applyStimulus(20, 0, 0, -1, 10);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_in_ready", in_ready, 0);
      checkOutput("mid_rst_rx_sym", rx_sym, 0);
      checkOutput("mid_rst_rx_sym_valid", rx_sym_valid, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_frame_done", frame_done, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("mid_rst_no_done", done_count, 0);
      frame_bytes.delete();
      applyStimulus(9, 1, 1, -1, -1);
      checkOutput("post_rst_count", sym_log.size(), 9);

      $display("[TB] random frames");
      for (int f = 0; f < 30; f++) begin
         int len;
         len = $urandom_range(1, 40);
         frame_bytes.delete();
         applyStimulus(len, $urandom_range(0, 1), $urandom_range(0, 2), -1, -1);
         checkOutput("rand_count", sym_log.size(), len);
         checkOutput("rand_bytes", m_bytes, (len + 3) / 4);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
